// File: rtl/recv2_cic_decim.sv
// Variable-rate (R8/R16/R32/R64) 5-stage CIC decimator for the receiver-2 I/Q path.
// Pipelined integrators run at the input strobe rate; registered combs run at the decimated rate.
module recv2_cic_decim #(
    parameter int IN_WIDTH  = 22,
    parameter int OUT_WIDTH = 24,
    parameter int STAGES    = 5,
    parameter int ACC_WIDTH = 52
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [1:0]                  rate_sel,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_I,
    input  logic signed [IN_WIDTH-1:0]  in_Q,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_I,
    output logic signed [OUT_WIDTH-1:0] out_Q
);

    localparam int GROWTH = OUT_WIDTH - IN_WIDTH;
    localparam int WARM_W = $clog2(STAGES + 1);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    logic [1:0]                  rate_q;
    logic [1:0]                  rate_cur;
    logic                        rate_change;
    logic                        accept;
    logic [5:0]                  dec_cnt;
    logic [5:0]                  dec_last;
    logic                        dec_pulse;
    logic [WARM_W-1:0]           warm_cnt;
    logic [4:0]                  shift;
    acc_t                        in_ext  [2];
    acc_t                        integ   [2][STAGES];
    acc_t                        pipe    [2][STAGES+1];
    acc_t                        dly     [2][STAGES];
    logic [STAGES:0]             pipe_vld;
    logic signed [OUT_WIDTH-1:0] scaled  [2];
    logic                        rnd     [2];
    logic signed [OUT_WIDTH-1:0] rounded [2];

    // Index 0 is I, index 1 is Q; both channels share every control signal.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        dec_last    = 6'd7;
        shift       = 5'(STAGES * 3 - GROWTH);
        rate_change = (rate_q != rate_cur);
        accept      = in_strobe && !rate_change;
        in_ext[0]   = {{(ACC_WIDTH-IN_WIDTH){in_I[IN_WIDTH-1]}}, in_I};
        in_ext[1]   = {{(ACC_WIDTH-IN_WIDTH){in_Q[IN_WIDTH-1]}}, in_Q};
        unique case (rate_cur)
            2'd0: begin dec_last = 6'd7;  shift = 5'(STAGES * 3 - GROWTH); end
            2'd1: begin dec_last = 6'd15; shift = 5'(STAGES * 4 - GROWTH); end
            2'd2: begin dec_last = 6'd31; shift = 5'(STAGES * 5 - GROWTH); end
            2'd3: begin dec_last = 6'd63; shift = 5'(STAGES * 6 - GROWTH); end
        endcase
        for (int c = 0; c < 2; c++) begin
            scaled[c] = OUT_WIDTH'(pipe[c][STAGES] >>> shift);
            rnd[c]    = pipe[c][STAGES][shift - 5'd1];
            if (rnd[c] && scaled[c] == OUT_MAX)
                rounded[c] = OUT_MAX;
            else
                rounded[c] = scaled[c] + OUT_WIDTH'(rnd[c]);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rate_q    <= '0;
            rate_cur  <= '0;
            dec_cnt   <= '0;
            dec_pulse <= 1'b0;
        end else begin
            rate_q <= rate_sel;
            if (rate_change) begin
                rate_cur  <= rate_q;
                dec_cnt   <= '0;
                dec_pulse <= 1'b0;
            end else begin
                dec_pulse <= accept && (dec_cnt == dec_last);
                if (accept)
                    dec_cnt <= (dec_cnt == dec_last) ? '0 : dec_cnt + 6'd1;
            end
        end
    end

    // Integrator wrap-around is harmless: the combs difference it away modulo 2^ACC_WIDTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: these arrays are flop banks, not RAM, so they take the async reset like any register.
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < STAGES; k++)
                    integ[c][k] <= '0;
        end else if (rate_change) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < STAGES; k++)
                    integ[c][k] <= '0;
        end else if (accept) begin
            for (int c = 0; c < 2; c++) begin
                integ[c][0] <= integ[c][0] + in_ext[c];
                for (int k = 1; k < STAGES; k++)
                    integ[c][k] <= integ[c][k] + integ[c][k-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s <= STAGES; s++) pipe[c][s] <= '0;
                for (int s = 0; s < STAGES; s++)  dly[c][s]  <= '0;
            end
        end else if (rate_change) begin
            pipe_vld <= '0;
            for (int c = 0; c < 2; c++) begin
                for (int s = 0; s <= STAGES; s++) pipe[c][s] <= '0;
                for (int s = 0; s < STAGES; s++)  dly[c][s]  <= '0;
            end
        end else begin
            pipe_vld <= {pipe_vld[STAGES-1:0], dec_pulse};
            for (int c = 0; c < 2; c++) begin
                if (dec_pulse)
                    pipe[c][0] <= integ[c][STAGES-1];
                for (int s = 0; s < STAGES; s++) begin
                    if (pipe_vld[s]) begin
                        pipe[c][s+1] <= pipe[c][s] - dly[c][s];
                        dly[c][s]    <= pipe[c][s];
                    end
                end
            end
        end
    end

    // The first STAGES decimated outputs after reset or a rate change are comb transients.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_strobe <= 1'b0;
            out_I      <= '0;
            out_Q      <= '0;
            warm_cnt   <= '0;
        end else if (rate_change) begin
            out_strobe <= 1'b0;
            warm_cnt   <= '0;
        end else begin
            out_strobe <= 1'b0;
            if (pipe_vld[STAGES]) begin
                if (warm_cnt == WARM_W'(STAGES)) begin
                    out_strobe <= 1'b1;
                    out_I      <= rounded[0];
                    out_Q      <= rounded[1];
                end else begin
                    warm_cnt <= warm_cnt + WARM_W'(1);
                end
            end
        end
    end

endmodule
